pe_ctx_seq: RTL and testbench

Per-PE context sequencer that sits directly upstream of the processing element and drives its `ctrl` word.
- Context words are loaded into a small local store over a valid/ready port.
- On `start`, the stored program is replayed one word per clock (optionally looped).
- Between runs the PE sees a harmless idle word.

---
 rtl/pe_ctx_seq_if.sv | 12 +
 rtl/pe_ctx_seq.sv | 141 ++++++++++++++
 tb/tb_pe_ctx_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pe_ctx_seq_if.sv
// Context-load port of pe_ctx_seq: one valid/ready transfer per accepted word.
interface pe_ctx_seq_if #(
  parameter int ctrl_width = 10
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [ctrl_width-1:0] cfg_word;
  logic                  cfg_last;

  modport master (output cfg_valid, output cfg_word, output cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_word, input cfg_last, output cfg_ready);
endinterface

// File: rtl/pe_ctx_seq.sv
// Per-PE context sequencer: loads a program of control words, then replays it onto ctrl.
// Define PE_CTX_LOOP_EN to add the loop_cnt port and repeated replay.
module pe_ctx_seq #(
  parameter int                    ctrl_width = 10,
  parameter int                    depth      = 16,
  parameter logic [ctrl_width-1:0] idle_word  = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  pe_ctx_seq_if.slave                cfg,
  input  logic                       clear,
  input  logic                       start,
`ifdef PE_CTX_LOOP_EN
  input  logic [7:0]                 loop_cnt,
`endif
  output logic [ctrl_width-1:0]      ctrl,
  output logic                       ctrl_valid,
  output logic [$clog2(depth)-1:0]   ctx_idx,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(depth);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_RUN} state_t;

  state_t                r_state, w_nxt_state;
  logic [ctrl_width-1:0] r_mem [depth];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr, w_nxt_rd;
  logic [AW:0]           r_len;
  logic [ctrl_width-1:0] r_ctrl;
  logic                  r_ctrl_valid, r_done;
  logic [AW-1:0]         r_ctx_idx;
  logic                  w_xfer, w_rd_last, w_nxt_iter_zero, w_run_last;
`ifdef PE_CTX_LOOP_EN
  logic [7:0]            r_iter, w_nxt_iter;
`endif

  assign cfg.cfg_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_xfer        = cfg.cfg_valid & cfg.cfg_ready;
  assign w_rd_last     = ({1'b0, r_rd_ptr} == r_len - (AW+1)'(1));
  assign busy          = (r_state == S_RUN);
  assign ctrl          = r_ctrl;
  assign ctrl_valid    = r_ctrl_valid;
  assign ctx_idx       = r_ctx_idx;
  assign done          = r_done;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rd    = r_rd_ptr;
`ifdef PE_CTX_LOOP_EN
    w_nxt_iter  = r_iter;
`endif
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_xfer)
          w_nxt_state = (cfg.cfg_last || r_wr_ptr == AW'(depth-1)) ? S_LOADED : S_LOAD;
      end
      S_LOADED: begin
        if (clear) begin
          w_nxt_state = S_IDLE;
        end else if (start) begin
          w_nxt_state = S_RUN;
          w_nxt_rd    = '0;
`ifdef PE_CTX_LOOP_EN
          w_nxt_iter  = loop_cnt;
`endif
        end
      end
      S_RUN: begin
        if (w_rd_last) begin
`ifdef PE_CTX_LOOP_EN
          if (r_iter != '0) begin
            w_nxt_rd   = '0;
            w_nxt_iter = r_iter - 8'd1;
          end else begin
            w_nxt_state = S_LOADED;
          end
`else
          w_nxt_state = S_LOADED;
`endif
        end else begin
          w_nxt_rd = r_rd_ptr + AW'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

`ifdef PE_CTX_LOOP_EN
  assign w_nxt_iter_zero = (w_nxt_iter == '0);
`else
  assign w_nxt_iter_zero = 1'b1;
`endif
  assign w_run_last = ({1'b0, w_nxt_rd} == r_len - (AW+1)'(1)) && w_nxt_iter_zero;

  always_ff @(posedge clk) begin
    if (w_xfer && !rst)
      r_mem[r_wr_ptr] <= cfg.cfg_word;
  end

  // Output registers load from the next-state word so mem[0] appears the cycle right after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
`ifdef PE_CTX_LOOP_EN
      r_iter       <= '0;
`endif
      r_ctrl       <= idle_word;
      r_ctrl_valid <= 1'b0;
      r_ctx_idx    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_rd_ptr <= w_nxt_rd;
`ifdef PE_CTX_LOOP_EN
      r_iter   <= w_nxt_iter;
`endif
      if (r_state == S_LOADED && clear) begin
        r_wr_ptr <= '0;
      end else if (w_xfer) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_nxt_state == S_LOADED)
          r_len <= {1'b0, r_wr_ptr} + (AW+1)'(1);
      end
      if (w_nxt_state == S_RUN) begin
        r_ctrl       <= r_mem[w_nxt_rd];
        r_ctrl_valid <= 1'b1;
        r_ctx_idx    <= w_nxt_rd;
        r_done       <= w_run_last;
      end else begin
        r_ctrl       <= idle_word;
        r_ctrl_valid <= 1'b0;
        r_ctx_idx    <= '0;
        r_done       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pe_ctx_seq.sv
// Self-checking bench for pe_ctx_seq: vector table, directed corner cases and a queue-based random model.
module tb_pe_ctx_seq;
  localparam int         CW    = 10;
  localparam int         DEPTH = 16;
  localparam logic [9:0] IDLE  = 10'h3FF;

  logic       clk = 1'b0;
  logic       rst, clear, start;
  logic [7:0] loop_cnt;
  logic [9:0] ctrl;
  logic       ctrl_valid, busy, done;
  logic [3:0] ctx_idx;

  pe_ctx_seq_if #(.ctrl_width(CW)) cfg_if ();

  pe_ctx_seq #(.ctrl_width(CW), .depth(DEPTH), .idle_word(IDLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg_if),
    .clear      (clear),
    .start      (start),
`ifdef PE_CTX_LOOP_EN
    .loop_cnt   (loop_cnt),
`endif
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .ctx_idx    (ctx_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
  endtask

  // Reference model: the held program plus a queue of words still to be shown.
  typedef struct { logic [9:0] w; int idx; bit last; } play_t;
  logic [9:0] m_loading[$];
  logic [9:0] m_prog[$];
  bit         m_have = 1'b0;
  play_t      m_play[$];

  task automatic model_edge();
    int reps;
    if (rst) begin
      m_loading.delete(); m_prog.delete(); m_play.delete(); m_have = 1'b0;
    end else if (m_play.size() != 0) begin
      void'(m_play.pop_front());
    end else if (m_have) begin
      if (clear) begin
        m_have = 1'b0; m_prog.delete();
      end else if (start) begin
`ifdef PE_CTX_LOOP_EN
        reps = int'(loop_cnt) + 1;
`else
        reps = 1;
`endif
        for (int r = 0; r < reps; r++)
          for (int i = 0; i < m_prog.size(); i++)
            m_play.push_back('{m_prog[i], i, (r == reps-1) && (i == m_prog.size()-1)});
      end
    end else if (cfg_if.cfg_valid) begin
      m_loading.push_back(cfg_if.cfg_word);
      if (cfg_if.cfg_last || m_loading.size() == DEPTH) begin
        m_prog = m_loading; m_have = 1'b1; m_loading.delete();
      end
    end
  endtask

  task automatic check_model();
    bit run;
    run = (m_play.size() != 0);
    check("ctrl",       32'(ctrl),         run ? 32'(m_play[0].w) : 32'(IDLE));
    check("ctrl_valid", 32'(ctrl_valid),   32'(run));
    check("ctx_idx",    32'(ctx_idx),      run ? 32'(m_play[0].idx) : 32'd0);
    check("busy",       32'(busy),         32'(run));
    check("done",       32'(done),         run ? 32'(m_play[0].last) : 32'd0);
    check("cfg_ready",  32'(cfg_if.cfg_ready), 32'(!m_have));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_in(input logic r, input logic v, input logic [9:0] w,
                        input logic l, input logic s, input logic c);
    rst = r; cfg_if.cfg_valid = v; cfg_if.cfg_word = w; cfg_if.cfg_last = l;
    start = s; clear = c;
  endtask

  task automatic load(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c2,
                      input logic [9:0] d, input int n);
    logic [9:0] ws [4];
    ws = '{a, b, c2, d};
    for (int i = 0; i < n; i++) begin
      set_in(0, 1, ws[i], i == n-1, 0, 0);
      step();
    end
    set_in(0, 0, 10'h0, 0, 0, 0);
  endtask

  typedef struct {
    logic r, v; logic [9:0] w; logic l, s, c;
    logic [9:0] e_ctrl; logic e_v; logic [3:0] e_idx; logic e_done, e_rdy;
  } vec_t;
  vec_t tbl [9];

  initial begin
    int vcnt, dcnt;
    bit last_done;
    loop_cnt = 8'd0;
    set_in(1, 0, 10'h0, 0, 0, 0);

    tbl[0] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 10'h001, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 10'h045, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 10'h10A, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h001, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h045, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h10A, 1'b1, 4'd2, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h3FF, 1'b0, 4'd0, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].r, tbl[i].v, tbl[i].w, tbl[i].l, tbl[i].s, tbl[i].c);
      step();
      check($sformatf("tbl%0d_ctrl", i),  32'(ctrl),       32'(tbl[i].e_ctrl));
      check($sformatf("tbl%0d_valid", i), 32'(ctrl_valid), 32'(tbl[i].e_v));
      check($sformatf("tbl%0d_idx", i),   32'(ctx_idx),    32'(tbl[i].e_idx));
      check($sformatf("tbl%0d_done", i),  32'(done),       32'(tbl[i].e_done));
      check($sformatf("tbl%0d_ready", i), 32'(cfg_if.cfg_ready), 32'(tbl[i].e_rdy));
    end
    set_in(0, 0, 10'h0, 0, 0, 0);

    // Full-depth program with no cfg_last marker.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(0, 1, 10'(i * 37 + 5), 0, 0, 0);
      step();
    end
    set_in(0, 0, 10'h0, 0, 0, 0);
    check("full_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    start = 1; step(); start = 0;
    for (int k = 1; k < DEPTH; k++) step();
    check("full_done_slot15", 32'({done, ctx_idx}), 32'({1'b1, 4'hF}));
    step();
    check("full_after_idle", 32'(ctrl), 32'(IDLE));

`ifdef PE_CTX_LOOP_EN
    clear = 1; step(); clear = 0;
    load(10'h155, 10'h2AA, 10'h0, 10'h0, 2);
    loop_cnt = 8'd2; start = 1; step(); start = 0; loop_cnt = 8'd0;
    vcnt = 0; dcnt = 0; last_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      vcnt += int'(ctrl_valid); dcnt += int'(done); last_done = done;
    end
    check("loop_valid_cycles", 32'(vcnt), 32'd6);
    check("loop_done_count", 32'(dcnt), 32'd1);
    check("loop_done_final", 32'({last_done, ctrl}), 32'({1'b1, 10'h2AA}));
    step();
    check("loop_after_valid", 32'(ctrl_valid), 32'd0);
`endif

    // Reset during the second cycle of a run.
    clear = 1; step(); clear = 0;
    load(10'h011, 10'h022, 10'h033, 10'h044, 4);
    start = 1; step(); start = 0;
    step();
    check("mid_run_word", 32'(ctrl), 32'h022);
    rst = 1; step(); rst = 0;
    check("rst_ctrl", 32'(ctrl), 32'(IDLE));
    check("rst_valid_done", 32'({ctrl_valid, done, busy}), 32'd0);
    start = 1; step(); start = 0;
    check("start_after_rst_ignored", 32'(ctrl_valid), 32'd0);
    check("ready_after_rst", 32'(cfg_if.cfg_ready), 32'd1);

    // cfg_valid held and start pulsed mid-run, then restart.
    load(10'h0A1, 10'h0B2, 10'h0C3, 10'h0D4, 4);
    start = 1; step(); start = 0;
    cfg_if.cfg_valid = 1; cfg_if.cfg_word = 10'h3C3;
    step(); start = 1; step(); start = 0; step();
    check("run_last_word", 32'({done, ctrl}), 32'({1'b1, 10'h0D4}));
    step();
    cfg_if.cfg_valid = 0;
    start = 1; step(); start = 0;
    check("restart_first", 32'(ctrl), 32'h0A1);
    for (int k = 0; k < 4; k++) step();

    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom % 100) == 0, $urandom % 2, 10'($urandom), ($urandom % 4) == 0,
             ($urandom % 3) == 0, ($urandom % 10) == 0);
      loop_cnt = 8'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
